// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Two-port arbiter and access sequencer in front of a single-ported data
// memory with registered read data.
//   - Port 0 (core load/store unit) and port 1 (debug/DMA loader) share the
//     memory port. At most one access is granted per cycle.
//   - Byte addresses are converted to word indices. Misaligned addresses and
//     addresses beyond the memory depth are granted but never reach memory;
//     they complete with an error flag.
//   - Every granted access completes exactly one cycle after its grant, which
//     hides the memory's one-cycle read latency behind a uniform response.
//
// Optional build macro:
//   DMEM_ARB_RR_EN  defined   -> round-robin arbitration on ties (last_gnt reg)
//                   undefined -> fixed priority, port 0 beats port 1
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   pN_req/we/addr/wdata       request side (N = 0,1), held stable until pN_gnt
//   pN_gnt                     combinational: access issued this cycle
//   pN_done/err/rdata          registered response, one cycle after pN_gnt
//   mem_r/mem_w/mem_addr/
//   mem_wdata                  memory command (mem_addr is a word index)
//   mem_rdata                  memory read data, valid the cycle after mem_r
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_done,
  output logic              p0_err,
  output logic [DATA_W-1:0] p0_rdata,

  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_done,
  output logic              p1_err,
  output logic [DATA_W-1:0] p1_rdata,

  output logic              mem_r,
  output logic              mem_w,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Raw arbitration result (before reset gating)
  logic win0;
  logic win1;

  // Issued access this cycle
  logic              issue0;
  logic              issue1;
  logic              issue_any;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              win_legal;

  // Response pipeline stage, captured at the grant edge
  logic resp_valid_q, resp_valid_d;
  logic resp_port_q,  resp_port_d;
  logic resp_rd_q,    resp_rd_d;
  logic resp_err_q,   resp_err_d;

  logic resp_rd_ok;

  // ---------------------------------------------------------------------------
  // Winner selection
  // ---------------------------------------------------------------------------
`ifdef DMEM_ARB_RR_EN
  // last_gnt_q holds the port granted most recently; on a tie the other port
  // wins. Reset value 1 makes port 0 win the first tie.
  logic last_gnt_q, last_gnt_d;

  always_comb begin
    win0 = p0_req & (~p1_req | last_gnt_q);
    win1 = p1_req & (~p0_req | ~last_gnt_q);
  end

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (issue1) begin
      last_gnt_d = 1'b1;
    end else if (issue0) begin
      last_gnt_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q <= 1'b1;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end
`else
  // Fixed priority: port 0 always wins; port 1 may starve under continuous
  // port 0 traffic.
  always_comb begin
    win0 = p0_req;
    win1 = p1_req & ~p0_req;
  end
`endif

  // ---------------------------------------------------------------------------
  // Issue path: grant, address check and memory command
  // ---------------------------------------------------------------------------
  always_comb begin
    // While reset is asserted nothing may be granted, even if requests are up.
    issue0    = win0 & rst_n;
    issue1    = win1 & rst_n;
    issue_any = issue0 | issue1;

    win_we    = issue1 ? p1_we    : p0_we;
    win_addr  = issue1 ? p1_addr  : p0_addr;
    win_wdata = issue1 ? p1_wdata : p0_wdata;

    // Word aligned and inside the 2**DEPTH_LOG2 word window
    win_legal = (win_addr[1:0] == 2'b00) &&
                ((win_addr >> (DEPTH_LOG2 + 2)) == '0);

    p0_gnt = issue0;
    p1_gnt = issue1;

    // Illegal winners are still granted, but the memory is not touched.
    mem_r     = issue_any & win_legal & ~win_we;
    mem_w     = issue_any & win_legal &  win_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (issue_any) begin
      mem_addr  = {{(ADDR_W - DEPTH_LOG2){1'b0}}, win_addr[DEPTH_LOG2+1:2]};
      mem_wdata = win_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Response stage
  // ---------------------------------------------------------------------------
  always_comb begin
    resp_valid_d = issue_any;
    resp_port_d  = issue1;
    resp_rd_d    = issue_any & ~win_we;
    resp_err_d   = issue_any & ~win_legal;
  end

  // Asynchronous reset clears any in-flight response, so no done appears
  // after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      resp_port_q  <= 1'b0;
      resp_rd_q    <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_port_q  <= resp_port_d;
      resp_rd_q    <= resp_rd_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Response fan-out: only the responding port sees done/err/rdata; memory
  // read data is forwarded only for legal reads, otherwise zero.
  always_comb begin
    resp_rd_ok = resp_rd_q & ~resp_err_q;

    p0_done  = resp_valid_q & ~resp_port_q;
    p1_done  = resp_valid_q &  resp_port_q;
    p0_err   = p0_done & resp_err_q;
    p1_err   = p1_done & resp_err_q;
    p0_rdata = (p0_done & resp_rd_ok) ? mem_rdata : '0;
    p1_rdata = (p1_done & resp_rd_ok) ? mem_rdata : '0;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter and access sequencer in front of the data memory.
- Shares the single memory port between port 0 (core load/store unit) and port 1 (debug/DMA loader).
- Converts byte addresses to word indices and rejects illegal addresses.
- Gives every granted access a uniform one-cycle completion/response, hiding the memory's registered read latency.

Parameters:
ADDR_W, 32, requester and memory address width
DATA_W, 32, data width
DEPTH_LOG2, 8, log2 of memory depth in words (256 words)

Ports:
clk  in  1  system clock, all registers on posedge
rst_n  in  1  asynchronous active-low reset
pN_req (N=0,1)  in  1  access request; requester holds req/we/addr/wdata stable until pN_gnt; may withdraw before grant
pN_we  in  1  1=write, 0=read
pN_addr  in  ADDR_W  byte address
pN_wdata  in  DATA_W  write data
pN_gnt  out  1  combinational; access issued this cycle
pN_done  out  1  registered; access completed, exactly one cycle after pN_gnt
pN_err  out  1  valid with pN_done; illegal address
pN_rdata  out  DATA_W  valid with pN_done for legal reads, else 0
mem_r  out  1  memory read enable
mem_w  out  1  memory write enable
mem_addr  out  ADDR_W  word index, zero-extended
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory registered read data; valid the cycle after mem_r

Behaviour:
- At most one grant per cycle. No requests: gnt=0, mem_r=mem_w=0, mem_addr=0, mem_wdata=0.
- Winner selection (combinational):
  - Default fixed priority: p0 beats p1.
  - Starvation of p1 under continuous p0 traffic is accepted in this mode.
- Legal address: addr[1:0]==0 and addr[ADDR_W-1:DEPTH_LOG2+2]==0.
- Legal winner:
  - mem_w=we, mem_r=~we.
  - mem_addr = addr[DEPTH_LOG2+1:2] zero-extended.
  - mem_wdata = winner wdata.
- Illegal winner: still granted; mem_r=mem_w=0, so memory is untouched.
- Response registers, captured at grant: resp_valid, resp_port, resp_rd, resp_err.
  - Next cycle: done and err are asserted only on resp_port.
  - rdata = mem_rdata if resp_rd & ~resp_err, else 0. Non-responding port: done=0, err=0, rdata=0.
- Throughput and hazards:
  - Fully pipelined; a new grant is allowed in the same cycle as the previous done, so sustained rate is 1 access/cycle.
  - Read-after-write to the same word in consecutive cycles returns the new data, since memory writes at the grant edge.
- Write completion: the write is committed at the grant edge; done is an acknowledge only.
- Reset behaviour:
  - While rst_n=0: all gnt, done, err, mem_r, mem_w = 0; rdata, mem_addr, mem_wdata = 0.
  - Reset asserted mid-operation discards any pending response; no done appears after release.
  - After release, the first grant is possible in the first clk edge cycle.
- Withdrawn request (req dropped before gnt): no side effects.

Optional Feature:
DMEM_ARB_RR_EN
- Defined: round-robin arbitration.
  - Register last_gnt, reset value 1, so p0 wins the first tie.
  - On a tie, the port not granted last wins; last_gnt updates on every grant.
  - Single requester is always granted immediately.
- Undefined: fixed priority p0>p1; no last_gnt register exists.

Test Plan:
1. After reset, p0 read addr 0x10 (memory preloaded word i=i) -> same cycle p0_gnt=1, mem_r=1, mem_addr=4; next cycle p0_done=1, p0_err=0, p0_rdata=4.
2. p1 write 0x20 data 0xDEADBEEF, then p1 read 0x20 next cycle -> read p1_done with p1_rdata=0xDEADBEEF; p0 outputs stay 0.
3. p0 and p1 both hold reads for 6 cycles:
   - Fixed mode: p0_gnt every cycle, p1_gnt never.
   - With DMEM_ARB_RR_EN: grants alternate p0,p1,p0,p1,...
4. p0 read 0x13, then p0 write 0x400 -> each gets gnt with mem_r=mem_w=0; next cycle done=1, err=1, rdata=0; memory contents unchanged.
5. p0 read 0x8 granted, rst_n pulsed low during the following cycle -> p0_done=0 throughout; after release, outputs idle at 0.
6. p0 back-to-back reads 0x0, 0x4, 0x8 -> p0_done high 3 consecutive cycles with rdata 0, 1, 2.
